page_addr_sequencer: RTL and testbench

//  Sequential address generator that drives the page-advance stage. Holds a 16-bit write pointer.
//  It steps the pointer by one per accepted data word, or jumps to the next 256-word page on request.
//  On overflow past 16'hFFFF it reloads a programmed base address and flags the wrap.

---
 rtl/page_seq_pkg.sv | 16 +
 rtl/next_page_calc.sv | 36 +++
 rtl/page_addr_sequencer.sv | 129 ++++++++++++
 tb/tb_page_addr_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/page_seq_pkg.sv
// Shared types and constants for the page address sequencer.
// The state enum is shared so benches and debug logic decode the same encoding.
package page_seq_pkg;

  typedef logic [15:0] addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  localparam int    PAGE_SHIFT_DEF = 8;
  localparam addr_t ADDR_MAX       = 16'hFFFF;

endpackage

// File: rtl/next_page_calc.sv
// Combinational pointer step: +1 for a normal beat, jump to the next page for a skip.
// A carry out of bit 15 means overflow, and the pointer reloads from base.
module next_page_calc
  import page_seq_pkg::*;
#(
  parameter int PAGE_SHIFT = PAGE_SHIFT_DEF
) (
  input  logic [15:0] ptr,
  input  logic [15:0] base,
  input  logic        skip,
  output logic [15:0] ptr_next,
  output logic        ovf,
  output logic        page_step
);

  localparam logic [16:0] PAGE_INC = 17'd1 << PAGE_SHIFT;
  localparam addr_t       LOW_MASK = addr_t'(PAGE_INC - 17'd1);

  logic [16:0] sum;

  always_comb begin
    sum       = '0;
    page_step = 1'b0;
    if (skip) begin
      sum       = {1'b0, ptr & ~LOW_MASK} + PAGE_INC;
      page_step = 1'b1;
    end else begin
      sum       = {1'b0, ptr} + 17'd1;
      // Landing on offset zero means the pointer rolled into a new page.
      page_step = ((sum[15:0] & LOW_MASK) == '0);
    end
    ovf      = sum[16];
    ptr_next = ovf ? base : sum[15:0];
  end

endmodule

// File: rtl/page_addr_sequencer.sv
// Write-pointer sequencer: one registered address per accepted beat, page jumps on skip,
// base reload on 16-bit overflow. The FSM state is exported on state_dbg.
module page_addr_sequencer
  import page_seq_pkg::*;
#(
  parameter int          PAGE_SHIFT = PAGE_SHIFT_DEF,
  parameter logic [15:0] DEF_BASE   = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] base_addr,
  input  logic        in_valid,
  input  logic        in_skip,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_addr,
  output logic        out_wrap,
  output logic        wrapped,
  output logic [7:0]  page_cnt,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both high.
  // Producers hold valid and payload stable until that edge; ready may depend on valid.

  seq_state_t  state_q, state_d;
  addr_t       ptr_q, ptr_d;
  logic        out_valid_q, out_valid_d;
  addr_t       out_addr_q, out_addr_d;
  logic        out_wrap_q, out_wrap_d;
  logic        wrapped_q, wrapped_d;
  logic [7:0]  page_cnt_q, page_cnt_d;

  logic        in_ready_c;
  logic        accept;
  addr_t       step_ptr;
  logic        step_ovf;
  logic        step_page;

  next_page_calc #(.PAGE_SHIFT(PAGE_SHIFT)) u_calc (
    .ptr       (ptr_q),
    .base      (base_addr),
    .skip      (in_skip),
    .ptr_next  (step_ptr),
    .ovf       (step_ovf),
    .page_step (step_page)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_wrap_d  = out_wrap_q;
    wrapped_d   = wrapped_q;
    page_cnt_d  = page_cnt_q;
    in_ready_c  = 1'b0;
    accept      = 1'b0;

    case (state_q)
      IDLE: begin
        // stop is ignored here; start is handled below for every state.
      end
      RUN: begin
        // A restart would drop the beat, so refuse it rather than lose it silently.
        in_ready_c = !start && (!out_valid_q || out_ready);
        accept     = in_valid && in_ready_c;
        if (accept) begin
          out_valid_d = 1'b1;
          out_addr_d  = step_ptr;
          out_wrap_d  = step_ovf;
          ptr_d       = step_ptr;
          if (step_ovf) wrapped_d = 1'b1;
          if (step_page && page_cnt_q != 8'hFF) page_cnt_d = page_cnt_q + 8'd1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
        if (stop) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_ready) out_valid_d = 1'b0;
        if (!out_valid_q || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d     = RUN;
      ptr_d       = base_addr;
      wrapped_d   = 1'b0;
      page_cnt_d  = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= DEF_BASE;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_wrap_q  <= 1'b0;
      wrapped_q   <= 1'b0;
      page_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_wrap_q  <= out_wrap_d;
      wrapped_q   <= wrapped_d;
      page_cnt_q  <= page_cnt_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_wrap  = out_wrap_q;
  assign wrapped   = wrapped_q;
  assign page_cnt  = page_cnt_q;
  assign busy      = (state_q != IDLE) || out_valid_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_page_addr_sequencer.sv
// Directed and randomized bench for page_addr_sequencer, checked against an arithmetic
// model of the pointer and an expected-address queue.
module tb_page_addr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, in_valid, in_skip, out_ready;
  logic [15:0] base_addr;
  logic        in_ready, out_valid, out_wrap, wrapped, busy;
  logic [15:0] out_addr;
  logic [7:0]  page_cnt;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  // Model: 0 idle, 1 running, 2 draining; exp_q holds {wrap, addr} of the pending output.
  int          m_mode;
  int          m_ptr;
  int          m_pc;
  bit          m_wrapped;
  logic [16:0] exp_q[$];

  page_addr_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .base_addr(base_addr),
    .in_valid(in_valid), .in_skip(in_skip), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_wrap(out_wrap), .wrapped(wrapped), .page_cnt(page_cnt), .busy(busy),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode    = 0;
    m_ptr     = 0;
    m_pc      = 0;
    m_wrapped = 0;
    exp_q.delete();
  endtask

  // Pointer rules in plain integer arithmetic: 256-word pages, overflow past 65535 reloads base.
  function automatic void calc(input int p, input bit sk, input int b,
                               output int nx, output bit ov, output bit pg);
    if (sk) begin
      nx = ((p / 256) + 1) * 256;
      pg = 1'b1;
    end else begin
      nx = p + 1;
      pg = (nx % 256) == 0;
    end
    ov = nx > 65535;
    if (ov) nx = b;
  endfunction

  // One clock: drive, check current outputs, advance the model, then cross the edge.
  task automatic step(input bit v, input bit sk, input bit ordy, input bit st,
                      input bit sp, input int base);
    bit rdy, acc, ov, pg;
    int nx;
    in_valid  = v;
    in_skip   = sk;
    out_ready = ordy;
    start     = st;
    stop      = sp;
    base_addr = base[15:0];
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      chk("out_addr", {16'd0, out_addr}, {16'd0, exp_q[0][15:0]});
      chk("out_wrap", {31'd0, out_wrap}, {31'd0, exp_q[0][16]});
    end
    chk("wrapped", {31'd0, wrapped}, {31'd0, m_wrapped});
    chk("page_cnt", {24'd0, page_cnt}, m_pc);
    chk("busy", {31'd0, busy}, {31'd0, (m_mode != 0) || (exp_q.size() != 0)});
    rdy = (m_mode == 1) && !st && (exp_q.size() == 0 || ordy);
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    acc = v && rdy;
    if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
    if (st) begin
      m_mode    = 1;
      m_ptr     = base & 16'hFFFF;
      m_pc      = 0;
      m_wrapped = 0;
      exp_q.delete();
    end else if (m_mode == 1) begin
      if (acc) begin
        calc(m_ptr, sk, base & 16'hFFFF, nx, ov, pg);
        exp_q.push_back({ov, nx[15:0]});
        m_ptr = nx;
        if (ov) m_wrapped = 1;
        if (pg && m_pc < 255) m_pc++;
      end
      if (sp) m_mode = 2;
    end else if (m_mode == 2) begin
      if (exp_q.size() == 0) m_mode = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 0; stop = 0; in_valid = 0; in_skip = 0; out_ready = 0;
    base_addr = '0;
    model_reset();
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_addr", {16'd0, out_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Three beats from base 1000 at full rate.
    step(0, 0, 1, 1, 0, 16'h1000);
    step(1, 0, 1, 0, 0, 16'h1000);
    step(1, 0, 1, 0, 0, 16'h1000);
    step(1, 0, 1, 0, 0, 16'h1000);
    step(0, 0, 1, 0, 0, 16'h1000);

    // Page jump from 12F0.
    step(0, 0, 1, 1, 0, 16'h12F0);
    step(1, 1, 1, 0, 0, 16'h12F0);
    step(0, 0, 1, 0, 0, 16'h12F0);

    // Overflow on a normal beat from FFFF and on a skip from FF22, reloading 0040.
    step(0, 0, 1, 1, 0, 16'hFFFF);
    step(1, 0, 1, 0, 0, 16'h0040);
    step(0, 0, 1, 0, 0, 16'h0040);
    step(0, 0, 1, 1, 0, 16'hFF22);
    step(1, 1, 1, 0, 0, 16'h0040);
    step(1, 0, 1, 0, 0, 16'h0040);
    step(0, 0, 1, 0, 0, 16'h0040);

    // Backpressure for four cycles, then full-rate release.
    step(0, 0, 1, 1, 0, 16'h2000);
    step(1, 0, 0, 0, 0, 16'h2000);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 16'h2000);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, 16'h2000);

    // Stop with a pending output under backpressure, then drain.
    step(1, 0, 0, 0, 1, 16'h2000);
    step(0, 0, 0, 0, 0, 16'h2000);
    step(0, 0, 0, 0, 0, 16'h2000);
    step(0, 0, 1, 0, 0, 16'h2000);
    step(0, 0, 1, 0, 0, 16'h2000);

    // Reset between edges mid-stream.
    step(0, 0, 1, 1, 0, 16'h3000);
    step(1, 1, 0, 0, 0, 16'h3000);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_addr", {16'd0, out_addr}, 32'd0);
    chk("mid_rst_page_cnt", {24'd0, page_cnt}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Restart while running drops the pending output and clears counters.
    step(0, 0, 1, 1, 0, 16'h40F0);
    step(1, 1, 0, 0, 0, 16'h40F0);
    step(0, 0, 0, 1, 0, 16'h5000);
    step(1, 0, 1, 0, 0, 16'h5000);
    step(0, 0, 1, 0, 0, 16'h5000);

    // Randomized traffic with bases biased toward the top of the address space.
    for (int i = 0; i < 600; i++) begin
      bit st, sp;
      int b;
      st = (m_mode == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
      sp = $urandom_range(0, 39) == 0;
      b  = $urandom_range(0, 1) ? $urandom_range(16'hFE00, 16'hFFFF) : $urandom_range(0, 16'hFFFF);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
           st, sp, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
